rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 select datapath.
- Four requesters each present a WIDTH-bit operand and a request line.
- The block grants one requester at a time, drives the 2-bit mux select, and moves the selected operand into a registered output stage with a valid/ready handshake.
- Per-grant burst length is bounded for fairness.

Parameters:
- WIDTH, 2: bit width of each operand and of out.
- HOLD, 2: maximum beats accepted from one grantee before forced release; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; req[i] belongs to requester i.
- in1  input  WIDTH  operand of requester 0.
- in2  input  WIDTH  operand of requester 1.
- in3  input  WIDTH  operand of requester 2.
- in4  input  WIDTH  operand of requester 3.
- ready  input  1  downstream accepts out this cycle when out_valid=1.
- gnt  output  4  one-hot grant; all zero when idle.
- sel  output  2  mux select of current/last grantee (00→in1, 01→in2, 10→in3, 11→in4).
- out  output  WIDTH  registered selected operand.
- out_valid  output  1  out holds an unconsumed beat.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge, overrides all activity including mid-burst and stalled beats:
  - gnt=0, sel=0, out=0, out_valid=0.
  - State=IDLE, rotating pointer ptr=0, beat counter cnt=0.
- States: IDLE, GRANT.
- Arbitration function: the first requester i with req[i]=1, scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - gnt=0.
  - If req≠0, the next cycle enters GRANT with gnt=onehot(winner), sel=winner, cnt=0.
  - Latency from request to grant is 1 cycle.
- Load condition, GRANT only: gnt[sel] & req[sel] & (!out_valid | ready). On load:
  - out <= operand[sel], out_valid <= 1, cnt <= cnt+1.
- Stall: out_valid & !ready → out, out_valid and cnt hold. Grant is kept even if the grantee's req drops.
- out_valid clears on ready & !load. Simultaneous ready and load replaces the beat with no bubble.
- Release from GRANT happens on either:
  - (a) req[sel]=0 and no stall; or
  - (b) a load occurs with cnt+1==HOLD.
- On release:
  - ptr <= sel+1 (mod 4).
  - Re-arbitrate among req, with the grantee's own bit masked if (b).
  - If a winner exists, the next cycle stays in GRANT with the new gnt/sel and cnt=0. Otherwise go to IDLE with gnt=0.
- sel retains its last value in IDLE; out is never driven from a non-granted requester.
- Exactly one gnt bit is high in GRANT; gnt is never multi-hot.
- A requester dropping req during a burst ends its grant after any pending stall resolves. A beat already in out stays until consumed.
- cnt counts only accepted loads and is 4 bits wide; it never exceeds HOLD.

Test Plan:
- Reset mid-burst: assert rst while gnt=0010 and out_valid=1 → next cycle gnt=0000, out=0, out_valid=0, sel=00; with req=0001 afterwards, gnt=0001 one cycle later.
- Single requester: req=0100, in3=2'b11, ready=1, HOLD=2 → gnt=0100 at cycle 1, out=11 valid at cycles 2-3. After 2 beats, release; re-grant to the same requester (sole requester, pointer moved to 3) after one IDLE cycle.
- Round-robin: req=1111 constant, ready=1, HOLD=1, in1..in4=00,01,10,11 → sel sequence 00,01,10,11,00; out sequence 00,01,10,11 with no idle cycles between grants.
- Backpressure: grantee 1 (in2=01), ready=0 for 3 cycles after first load → out=01 and out_valid held, cnt unchanged, gnt held. When ready=1, the second beat loads the same cycle.
- Early drop: req=0011, grantee 0 drops req after 1 beat (HOLD=2) → next grant is 0010 with ptr=1; requester 0 is not re-granted until requester 1 releases.
- Simultaneous ready and load: out_valid=1, ready=1, load in the same cycle → out updates to the new operand and out_valid stays 1 without a bubble.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter and sequencer for a shared 4:1 select datapath. Four
// requesters each offer a WIDTH-bit operand plus a request line. One
// requester holds the grant at a time. Its operand is steered through the
// mux and loaded into a registered output stage that a valid/ready
// handshake drains. A grant is forcibly released after HOLD accepted beats,
// so a busy requester cannot starve the others.
//
// Parameters
//   WIDTH     operand / output width
//   HOLD      max beats per grant before forced release (1..15)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req[3:0]   in   request lines, req[i] belongs to requester i
//   in1..in4   in   operands of requesters 0..3
//   ready      in   downstream takes out this cycle when out_valid=1
//   gnt[3:0]   out  one-hot grant, zero when idle
//   sel[1:0]   out  mux select of current / last grantee
//   out        out  registered selected operand
//   out_valid  out  out holds an unconsumed beat
//
// Handshake: a beat in out is transferred on a cycle where out_valid=1 and
// ready=1. out and out_valid are stable while out_valid=1 and ready=0. A
// new beat may be loaded in the same cycle the old one is taken, so
// back-to-back beats leave no bubble.
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
   parameter int WIDTH = 2,
   parameter int HOLD  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic             ready,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] HOLD_L = 4'(HOLD);

   // Registered state
   state_t           state;
   logic [1:0]       ptr;
   logic [3:0]       cnt;

   // Next-state values
   state_t           state_nxt;
   logic [1:0]       ptr_nxt;
   logic [3:0]       cnt_nxt;
   logic [3:0]       gnt_nxt;
   logic [1:0]       sel_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic             out_valid_nxt;

   // Datapath / control helpers
   logic [WIDTH-1:0] operand;
   logic             stall;
   logic             load;
   logic             last_beat;
   logic             release_grant;
   logic [3:0]       masked_req;
   logic [1:0]       scan_start;
   logic [2:0]       pick;

   // Round-robin pick: returns {found, index} of the first set bit of r
   // scanning p, p+1, ... modulo 4. Scanning from the far end and
   // overwriting leaves the nearest hit.
   function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                          input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   // Shared 4:1 operand mux
   always_comb begin
      case (sel)
         2'd0:    operand = in1;
         2'd1:    operand = in2;
         2'd2:    operand = in3;
         default: operand = in4;
      endcase
   end

   // Handshake and release conditions
   always_comb begin
      stall     = out_valid & ~ready;
      load      = (state == GRANT) & gnt[sel] & req[sel]
                  & (~out_valid | ready);
      last_beat = load & ((cnt + 4'd1) == HOLD_L);
      // A dropped request only releases once any stalled beat has moved on.
      release_grant = (state == GRANT)
                      & ((~req[sel] & ~stall) | last_beat);
   end

   // Arbitration input: on a forced release the outgoing grantee is masked
   // so another requester gets a turn. On an early drop its bit is already
   // zero. In IDLE the scan starts at the stored pointer. On release it
   // starts just past the outgoing grantee, which is also the new pointer.
   always_comb begin
      masked_req = req;
      scan_start = ptr;
      if (state == GRANT) begin
         scan_start = sel + 2'd1;
         if (last_beat) masked_req = req & ~(4'b0001 << sel);
      end
      pick = rr_pick(masked_req, scan_start);
   end

   // Next-state / output logic
   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      cnt_nxt       = cnt;
      gnt_nxt       = gnt;
      sel_nxt       = sel;
      out_nxt       = out;
      out_valid_nxt = out_valid;

      // Output stage: a load replaces the beat. Otherwise a taken beat
      // empties the stage.
      if (load) begin
         out_nxt       = operand;
         out_valid_nxt = 1'b1;
         cnt_nxt       = cnt + 4'd1;
      end else if (ready) begin
         out_valid_nxt = 1'b0;
      end

      case (state)
         IDLE: begin
            gnt_nxt = 4'b0000;
            if (pick[2]) begin
               state_nxt = GRANT;
               gnt_nxt   = 4'b0001 << pick[1:0];
               sel_nxt   = pick[1:0];
               cnt_nxt   = 4'd0;
            end
         end

         GRANT: begin
            if (release_grant) begin
               ptr_nxt = scan_start;
               cnt_nxt = 4'd0;
               if (pick[2]) begin
                  state_nxt = GRANT;
                  gnt_nxt   = 4'b0001 << pick[1:0];
                  sel_nxt   = pick[1:0];
               end else begin
                  // sel keeps the last grantee while idle
                  state_nxt = IDLE;
                  gnt_nxt   = 4'b0000;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 2'd0;
         cnt       <= 4'd0;
         gnt       <= 4'b0000;
         sel       <= 2'd0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         cnt       <= cnt_nxt;
         gnt       <= gnt_nxt;
         sel       <= sel_nxt;
         out       <= out_nxt;
         out_valid <= out_valid_nxt;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Directed bench for rr_mux_arbiter. Two instances share one stimulus
// stream: u_h2 (HOLD=2) and u_h1 (HOLD=1). Each scenario checks the
// instance whose HOLD it targets. Inputs change 1 time unit after a rising
// edge. Outputs are sampled at the same point, so each check sees the
// registers updated by the edge just passed.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;

   localparam int WIDTH = 2;

   logic             clk;
   logic             rst;
   logic [3:0]       req;
   logic [WIDTH-1:0] in1, in2, in3, in4;
   logic             ready;

   logic [3:0]       gnt_h2, gnt_h1;
   logic [1:0]       sel_h2, sel_h1;
   logic [WIDTH-1:0] out_h2, out_h1;
   logic             ov_h2, ov_h1;

   int checks   = 0;
   int failures = 0;

   rr_mux_arbiter #(.WIDTH(WIDTH), .HOLD(2)) u_h2 (
      .clk(clk), .rst(rst), .req(req),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .ready(ready),
      .gnt(gnt_h2), .sel(sel_h2), .out(out_h2), .out_valid(ov_h2)
   );

   rr_mux_arbiter #(.WIDTH(WIDTH), .HOLD(1)) u_h1 (
      .clk(clk), .rst(rst), .req(req),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .ready(ready),
      .gnt(gnt_h1), .sel(sel_h1), .out(out_h1), .out_valid(ov_h1)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks all four outputs of one instance at once.
   task automatic chk_h2(input string tag, input logic [3:0] g,
                         input logic [1:0] s, input logic [1:0] o,
                         input logic v);
      chk({tag, ".gnt"}, 32'(gnt_h2), 32'(g));
      chk({tag, ".sel"}, 32'(sel_h2), 32'(s));
      chk({tag, ".out"}, 32'(out_h2), 32'(o));
      chk({tag, ".ov"},  32'(ov_h2),  32'(v));
   endtask

   task automatic chk_h1(input string tag, input logic [3:0] g,
                         input logic [1:0] s, input logic [1:0] o,
                         input logic v);
      chk({tag, ".gnt"}, 32'(gnt_h1), 32'(g));
      chk({tag, ".sel"}, 32'(sel_h1), 32'(s));
      chk({tag, ".out"}, 32'(out_h1), 32'(o));
      chk({tag, ".ov"},  32'(ov_h1),  32'(v));
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; ready = 1'b0;
      in1 = 2'b00; in2 = 2'b00; in3 = 2'b00; in4 = 2'b00;
      tick(); tick();

      // ---- Reset state --------------------------------------------------
      chk_h2("rst_h2", 4'b0000, 2'b00, 2'b00, 1'b0);
      chk_h1("rst_h1", 4'b0000, 2'b00, 2'b00, 1'b0);
      chk("rst_cnt", 32'(u_h2.cnt), 32'd0);
      chk("rst_ptr", 32'(u_h2.ptr), 32'd0);

      // ---- Single requester, HOLD=2 -------------------------------------
      rst = 1'b0; req = 4'b0100; in3 = 2'b11; ready = 1'b1;
      tick();  // IDLE saw req -> grant
      chk_h2("single_c1", 4'b0100, 2'b10, 2'b00, 1'b0);
      tick();  // beat 1 loaded
      chk_h2("single_c2", 4'b0100, 2'b10, 2'b11, 1'b1);
      chk("single_c2_cnt", 32'(u_h2.cnt), 32'd1);
      tick();  // beat 2 loaded, forced release, sole requester masked
      chk_h2("single_c3", 4'b0000, 2'b10, 2'b11, 1'b1);
      chk("single_c3_ptr", 32'(u_h2.ptr), 32'd3);
      tick();  // one IDLE cycle, then re-granted
      chk_h2("single_c4", 4'b0100, 2'b10, 2'b11, 1'b0);

      // ---- Round robin, HOLD=1 ------------------------------------------
      rst = 1'b1; req = 4'b0000;
      tick();
      rst = 1'b0; req = 4'b1111; ready = 1'b1;
      in1 = 2'b00; in2 = 2'b01; in3 = 2'b10; in4 = 2'b11;
      tick();
      chk_h1("rr_c1", 4'b0001, 2'b00, 2'b00, 1'b0);
      tick();
      chk_h1("rr_c2", 4'b0010, 2'b01, 2'b00, 1'b1);
      tick();
      chk_h1("rr_c3", 4'b0100, 2'b10, 2'b01, 1'b1);
      tick();
      chk_h1("rr_c4", 4'b1000, 2'b11, 2'b10, 1'b1);
      tick();
      chk_h1("rr_c5", 4'b0001, 2'b00, 2'b11, 1'b1);

      // ---- Backpressure + simultaneous ready/load, HOLD=2 ---------------
      rst = 1'b1; req = 4'b0000;
      tick();
      rst = 1'b0; req = 4'b0010; in2 = 2'b01; ready = 1'b0;
      tick();
      chk_h2("bp_grant", 4'b0010, 2'b01, 2'b00, 1'b0);
      tick();  // first load goes in because the stage was empty
      chk_h2("bp_load1", 4'b0010, 2'b01, 2'b01, 1'b1);
      in2 = 2'b10;  // changes under stall must not reach out
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_h2("bp_stall", 4'b0010, 2'b01, 2'b01, 1'b1);
         chk("bp_stall_cnt", 32'(u_h2.cnt), 32'd1);
      end
      ready = 1'b1;
      tick();  // old beat taken, beat 2 loaded same cycle, forced release
      chk_h2("bp_load2", 4'b0000, 2'b01, 2'b10, 1'b1);
      tick();  // IDLE: beat drained, sole requester re-granted
      chk_h2("bp_regrant", 4'b0010, 2'b01, 2'b10, 1'b0);
      in2 = 2'b11;
      tick();
      chk_h2("bp_load3", 4'b0010, 2'b01, 2'b11, 1'b1);

      // ---- Reset mid-burst ----------------------------------------------
      rst = 1'b1; req = 4'b0001;
      tick();
      chk_h2("midrst", 4'b0000, 2'b00, 2'b00, 1'b0);
      chk("midrst_cnt", 32'(u_h2.cnt), 32'd0);
      rst = 1'b0;
      tick();
      chk_h2("midrst_grant", 4'b0001, 2'b00, 2'b00, 1'b0);

      // ---- Early drop, HOLD=2 -------------------------------------------
      rst = 1'b1; req = 4'b0000;
      tick();
      rst = 1'b0; req = 4'b0011; ready = 1'b1; in1 = 2'b01; in2 = 2'b10;
      tick();
      chk_h2("drop_c1", 4'b0001, 2'b00, 2'b00, 1'b0);
      tick();  // one beat from requester 0
      chk_h2("drop_c2", 4'b0001, 2'b00, 2'b01, 1'b1);
      req = 4'b0010;
      tick();  // requester 0 dropped -> release to requester 1
      chk_h2("drop_c3", 4'b0010, 2'b01, 2'b01, 1'b0);
      chk("drop_c3_ptr", 32'(u_h2.ptr), 32'd1);
      req = 4'b0011;
      tick();  // requester 1 keeps grant despite requester 0 asking again
      chk_h2("drop_c4", 4'b0010, 2'b01, 2'b10, 1'b1);
      tick();  // requester 1 hits HOLD, requester 0 wins next
      chk_h2("drop_c5", 4'b0001, 2'b00, 2'b10, 1'b1);
      chk("drop_c5_ptr", 32'(u_h2.ptr), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
